// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver with address match, ACK and clock stretching.
// Received bytes leave on a valid/ready handshake; SCL is held low when full.
`timescale 1ns/1ps
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, STRETCH, IGNORE
  } state_t;

  state_t      state, state_n;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  rx_data_n;
  logic        rx_valid_n;
  logic        sda_oe_n, scl_oe_n, stop_det_n;

  logic        scl_rise, scl_fall, scl_hi;
  logic        start_c, stop_c;
  logic [7:0]  shift_in;

  // Pad synchronizers plus edge register; idle-high reset avoids false events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // SCL must be stably high so our own SCL release next to an ACK
  // pull-down is never taken for a START.
  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign scl_hi   = scl_s2 & scl_d;
  assign start_c  = scl_hi & ~sda_s2 & sda_d;
  assign stop_c   = scl_hi & sda_s2 & ~sda_d;
  assign shift_in = {shift[6:0], sda_s2};
  assign busy     = (state != IDLE) && (state != IGNORE);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shift    <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sda_oe   <= 1'b0;
      scl_oe   <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      sda_oe   <= sda_oe_n;
      scl_oe   <= scl_oe_n;
      stop_det <= stop_det_n;
    end
  end

  // Next-state, bit capture, ACK/stretch control and byte handoff.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shift_n    = shift;
    rx_data_n  = rx_data;
    rx_valid_n = rx_valid;
    sda_oe_n   = sda_oe;
    scl_oe_n   = scl_oe;
    stop_det_n = 1'b0;

    if (rx_valid && rx_ready)
      rx_valid_n = 1'b0;

    if (stop_c) begin
      state_n    = IDLE;
      cnt_n      = 4'd0;
      shift_n    = 8'h00;
      sda_oe_n   = 1'b0;
      scl_oe_n   = 1'b0;
      stop_det_n = 1'b1;
    end else if (start_c) begin
      state_n  = ADDR;
      cnt_n    = 4'd0;
      shift_n  = 8'h00;
      sda_oe_n = 1'b0;
      scl_oe_n = 1'b0;
    end else begin
      unique case (state)
        IDLE, IGNORE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            shift_n = shift_in;
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n = 4'd0;
              if (shift_in[7:1] == TARGET_ADDR && !shift_in[0])
                state_n = ADDR_ACK;
              else
                state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = DATA;
              cnt_n    = 4'd0;
            end
          end
        end
        DATA: begin
          if (scl_rise && cnt < 4'd8) begin
            shift_n = shift_in;
            cnt_n   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = 4'd0;
            if (!rx_valid) begin
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
              sda_oe_n   = 1'b1;
              state_n    = DATA_ACK;
            end else begin
              scl_oe_n = 1'b1;
              state_n  = STRETCH;
            end
          end
        end
        STRETCH: begin
          if (!rx_valid) begin
            rx_data_n  = shift;
            rx_valid_n = 1'b1;
            sda_oe_n   = 1'b1;
            scl_oe_n   = 1'b0;
            state_n    = DATA_ACK;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = DATA;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
